// File: rtl/mem_copy_dma_pkg.sv
// rtl/mem_copy_dma_pkg.sv - shared defaults and FSM state type for the memory copy DMA
package mem_pkg;

    localparam int MEM_WIDTH = 16;
    localparam int MEM_DEPTH = 1024;
    localparam int ADD_SIZE  = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mem_state_e;

endpackage

// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - RAM port bundle between the copy DMA (master) and the target RAM (slave)
// Signals: ram_din/ram_addr_wr/ram_wr_en write side, ram_addr_rd/ram_rd_en read side,
// ram_blk_select block strobe, ram_dout registered read data returned by the RAM.
interface mem_copy_dma_if #(
    parameter int MEM_WIDTH = mem_pkg::MEM_WIDTH,
    parameter int ADD_SIZE  = mem_pkg::ADD_SIZE
);
    logic [MEM_WIDTH-1:0] ram_din;
    logic [MEM_WIDTH-1:0] ram_dout;
    logic [ADD_SIZE-1:0]  ram_addr_wr;
    logic [ADD_SIZE-1:0]  ram_addr_rd;
    logic                 ram_wr_en;
    logic                 ram_rd_en;
    logic                 ram_blk_select;

    modport master (
        output ram_din, ram_addr_wr, ram_addr_rd, ram_wr_en, ram_rd_en, ram_blk_select,
        input  ram_dout
    );

    modport slave (
        input  ram_din, ram_addr_wr, ram_addr_rd, ram_wr_en, ram_rd_en, ram_blk_select,
        output ram_dout
    );
endinterface

// File: rtl/mem_copy_dma_addr_gen.sv
// rtl/mem_copy_dma_addr_gen.sv - source/destination address sequencer for the copy DMA
// Ports: load captures src_addr/dst_addr/len/descending; issue marks a cycle in which the
// read at rd_addr is on the bus; rd_addr is the current read address, wr_addr the previous
// read address remapped to the destination, last flags the final read of the request.
module mem_copy_addr_gen #(
    parameter int ADD_SIZE = mem_pkg::ADD_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                descending,
    input  logic                issue,
    input  logic [ADD_SIZE-1:0] src_addr,
    input  logic [ADD_SIZE-1:0] dst_addr,
    input  logic [ADD_SIZE:0]   len,
    output logic [ADD_SIZE-1:0] rd_addr,
    output logic [ADD_SIZE-1:0] wr_addr,
    output logic                last
);

    localparam logic [ADD_SIZE:0] ONE = {{ADD_SIZE{1'b0}}, 1'b1};

    logic [ADD_SIZE-1:0] base_src;
    logic [ADD_SIZE-1:0] base_dst;
    logic                desc;
    logic [ADD_SIZE:0]   offset;
    logic [ADD_SIZE:0]   remaining;
    logic [ADD_SIZE:0]   start_off;
    logic [ADD_SIZE:0]   next_off;

    // A descending copy starts at the top word so overlapping source words are read first.
    assign start_off = descending ? (len - ONE) : '0;
    assign next_off  = desc ? (offset - ONE) : (offset + ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            base_src  <= '0;
            base_dst  <= '0;
            desc      <= 1'b0;
            offset    <= '0;
            remaining <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            last      <= 1'b0;
        end else if (load) begin
            base_src  <= src_addr;
            base_dst  <= dst_addr;
            desc      <= descending;
            offset    <= start_off;
            remaining <= len - ONE;
            rd_addr   <= src_addr + start_off[ADD_SIZE-1:0];
            last      <= (len == ONE);
        end else if (issue) begin
            // The word read this cycle lands on ram_dout next cycle, so its
            // destination address must trail the read address by one cycle.
            wr_addr <= base_dst + offset[ADD_SIZE-1:0];
            if (!last) begin
                offset    <= next_off;
                remaining <= remaining - ONE;
                rd_addr   <= base_src + next_off[ADD_SIZE-1:0];
                last      <= (remaining == ONE);
            end
        end
    end

endmodule

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - single-RAM word copy engine with overlap-safe direction and range checks
// Ports: clk, rst (sync active-high); start/src_addr/dst_addr/len request; busy, done,
// error status pulses; ram (mem_copy_dma_if.master) RAM read/write port.
module mem_copy_dma #(
    parameter int MEM_WIDTH = mem_pkg::MEM_WIDTH,
    parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH,
    parameter int ADD_SIZE  = mem_pkg::ADD_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADD_SIZE-1:0] src_addr,
    input  logic [ADD_SIZE-1:0] dst_addr,
    input  logic [ADD_SIZE:0]   len,
    output logic                busy,
    output logic                done,
    output logic                error,
    mem_copy_dma_if.master      ram
);

    import mem_pkg::*;

    localparam logic [ADD_SIZE+1:0] DEPTH_LIM = (ADD_SIZE+2)'(MEM_DEPTH);

    mem_state_e           state;
    logic [ADD_SIZE+1:0]  src_end;
    logic [ADD_SIZE+1:0]  dst_end;
    logic                 out_of_range;
    logic                 overlap;
    logic                 len_zero;
    logic                 accept;
    logic                 rd_en;
    logic                 wr_en;
    logic                 blk_sel;
    logic                 last;
    logic [ADD_SIZE-1:0]  rd_addr;
    logic [ADD_SIZE-1:0]  wr_addr;
    logic [MEM_WIDTH-1:0] pass_data;

    // End addresses are widened by two bits so a request running past the RAM cannot wrap.
    assign src_end      = {2'b00, src_addr} + {1'b0, len};
    assign dst_end      = {2'b00, dst_addr} + {1'b0, len};
    assign out_of_range = (src_end > DEPTH_LIM) || (dst_end > DEPTH_LIM);
    assign overlap      = (dst_addr > src_addr) && ({2'b00, dst_addr} < src_end);
    assign len_zero     = (len == '0);
    assign accept       = (state == IDLE) && start && !len_zero && !out_of_range;

    mem_copy_addr_gen #(
        .ADD_SIZE (ADD_SIZE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .descending (overlap),
        .issue      (rd_en),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            blk_sel <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (start) begin
                        if (len_zero || out_of_range) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= out_of_range;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            blk_sel <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Every read is followed one cycle later by its write.
                    wr_en   <= 1'b1;
                    blk_sel <= 1'b1;
                    if (last) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    wr_en   <= 1'b0;
                    blk_sel <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pass_data          = ram.ram_dout;
    assign ram.ram_din        = pass_data;
    assign ram.ram_addr_rd    = rd_addr;
    assign ram.ram_addr_wr    = wr_addr;
    assign ram.ram_rd_en      = rd_en;
    assign ram.ram_wr_en      = wr_en;
    assign ram.ram_blk_select = blk_sel;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - directed self-checking bench for mem_copy_dma
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic        preload;

    mem_copy_dma_if #(.MEM_WIDTH(16), .ADD_SIZE(10)) ram ();

    mem_copy_dma #(
        .MEM_WIDTH (16),
        .MEM_DEPTH (1024),
        .ADD_SIZE  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .ram      (ram)
    );

    always #5 clk = ~clk;

    logic [15:0] mem  [0:1023];
    logic [15:0] snap [0:1023];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 16'h1000 + 16'(k);
        end else if (ram.ram_blk_select && ram.ram_wr_en) begin
            mem[ram.ram_addr_wr] <= ram.ram_din;
        end
        if (ram.ram_blk_select && ram.ram_rd_en) ram.ram_dout <= mem[ram.ram_addr_rd];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int done_cyc, err_at_done, done_cnt;
    int n_rd, n_wr, first_rd, last_rd, first_wr, last_wr, busy_first, busy_last, blk_bad;
    logic [9:0] rd_q [$];

    // Pulses start with the given request (sampled at edge 0) and records cycles 1..max_cyc.
    // poke_at: cycle in which a second start with other operands is driven.
    // rst_at: cycle in which rst is driven high (sampled at the edge ending that cycle).
    task automatic run(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                       input int max_cyc, input int poke_at, input int rst_at);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clk);
        start = 1'b0;
        done_cyc = 0; err_at_done = 0; done_cnt = 0;
        n_rd = 0; n_wr = 0; first_rd = 0; last_rd = 0; first_wr = 0; last_wr = 0;
        busy_first = 0; busy_last = 0; blk_bad = 0;
        rd_q.delete();
        for (int c = 1; c <= max_cyc; c++) begin
            if (ram.ram_rd_en) begin
                n_rd++; if (first_rd == 0) first_rd = c; last_rd = c;
                rd_q.push_back(ram.ram_addr_rd);
            end
            if (ram.ram_wr_en) begin
                n_wr++; if (first_wr == 0) first_wr = c; last_wr = c;
            end
            if (busy) begin
                if (busy_first == 0) busy_first = c; busy_last = c;
            end
            if (ram.ram_blk_select !== (ram.ram_rd_en | ram.ram_wr_en)) blk_bad++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin done_cyc = c; err_at_done = int'(error); end
            end
            start = (c == poke_at);
            if (c == poke_at) begin src_addr = 10'h060; dst_addr = 10'h360; len = 11'd2; end
            rst = (c == rst_at);
            if (done_cyc != 0 && c >= done_cyc + 2) break;
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_mem(input string tag, input int base, input int exp_base, input int n);
        for (int i = 0; i < n; i++) check(tag, 32'(mem[base + i]), 32'(16'h1000 + 16'(exp_base + i)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; preload = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_rd_en", 32'(ram.ram_rd_en), 0);
        check("rst_wr_en", 32'(ram.ram_wr_en), 0);
        check("rst_blk", 32'(ram.ram_blk_select), 0);
        check("rst_addr_rd", 32'(ram.ram_addr_rd), 0);
        check("rst_addr_wr", 32'(ram.ram_addr_wr), 0);

        // start together with rst must be dropped
        start = 1'b1; src_addr = 10'h010; dst_addr = 10'h200; len = 11'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 0);
        check("rst_start_rd_en", 32'(ram.ram_rd_en), 0);
        @(negedge clk);

        // basic ascending copy
        run(10'h010, 10'h200, 11'd4, 30, 0, 0);
        check("asc_done_cyc", done_cyc, 6);
        check("asc_error", err_at_done, 0);
        check("asc_done_cnt", done_cnt, 1);
        check("asc_n_rd", n_rd, 4);
        check("asc_n_wr", n_wr, 4);
        check("asc_first_rd", first_rd, 1);
        check("asc_last_rd", last_rd, 4);
        check("asc_first_wr", first_wr, 2);
        check("asc_last_wr", last_wr, 5);
        check("asc_busy_first", busy_first, 1);
        check("asc_busy_last", busy_last, 5);
        check("asc_blk", blk_bad, 0);
        check("asc_rd_q_size", rd_q.size(), 4);
        for (int i = 0; i < rd_q.size(); i++) check("asc_rd_addr", 32'(rd_q[i]), 32'(10'h010 + i));
        check_mem("asc_mem", 10'h200, 10'h010, 4);

        // overlapping, destination above source: descending
        run(10'h020, 10'h022, 11'd5, 30, 0, 0);
        check("ovl_done_cyc", done_cyc, 7);
        check("ovl_n_wr", n_wr, 5);
        check("ovl_rd_q_size", rd_q.size(), 5);
        for (int i = 0; i < rd_q.size(); i++) check("ovl_rd_addr", 32'(rd_q[i]), 32'(10'h024 - i));
        check_mem("ovl_mem", 10'h022, 10'h020, 5);

        // zero length
        run(10'h100, 10'h300, 11'd0, 10, 0, 0);
        check("len0_done_cyc", done_cyc, 1);
        check("len0_error", err_at_done, 0);
        check("len0_n_rd", n_rd, 0);
        check("len0_n_wr", n_wr, 0);

        // source overruns the RAM
        run(10'h3FE, 10'h100, 11'd3, 10, 0, 0);
        check("src_oor_done_cyc", done_cyc, 1);
        check("src_oor_error", err_at_done, 1);
        check("src_oor_n_rd", n_rd, 0);
        check("src_oor_n_wr", n_wr, 0);
        check_mem("src_oor_mem", 10'h100, 10'h100, 3);

        // destination overruns the RAM
        run(10'h000, 10'h3FF, 11'd2, 10, 0, 0);
        check("dst_oor_done_cyc", done_cyc, 1);
        check("dst_oor_error", err_at_done, 1);
        check("dst_oor_n_wr", n_wr, 0);

        // source ends exactly at the top of the RAM: legal
        run(10'h3FC, 10'h300, 11'd4, 30, 0, 0);
        check("edge_done_cyc", done_cyc, 6);
        check("edge_error", err_at_done, 0);
        check_mem("edge_mem", 10'h300, 10'h3FC, 4);

        // source == destination
        run(10'h050, 10'h050, 11'd3, 30, 0, 0);
        check("same_done_cyc", done_cyc, 5);
        check("same_n_rd", n_rd, 3);
        check("same_n_wr", n_wr, 3);
        check_mem("same_mem", 10'h050, 10'h050, 3);

        // reset in the middle of an 8-word copy
        run(10'h080, 10'h280, 11'd8, 15, 0, 3);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_n_rd", n_rd, 3);
        check("abort_n_wr", n_wr, 2);
        check("abort_last_wr", last_wr, 3);
        check("abort_busy_last", busy_last, 3);
        check("abort_addr_rd", 32'(ram.ram_addr_rd), 0);
        check_mem("abort_mem", 10'h280, 10'h080, 2);
        check("abort_mem_untouched", 32'(mem[10'h282]), 32'h1282);

        // start while busy is ignored
        run(10'h040, 10'h240, 11'd6, 30, 2, 0);
        check("busy_start_done_cyc", done_cyc, 8);
        check("busy_start_n_rd", n_rd, 6);
        check("busy_start_n_wr", n_wr, 6);
        check_mem("busy_start_mem", 10'h240, 10'h040, 6);
        check("busy_start_other", 32'(mem[10'h360]), 32'h1360);

        // start while in DONE is ignored
        run(10'h070, 10'h270, 11'd1, 20, 3, 0);
        check("done_start_done_cyc", done_cyc, 3);
        check("done_start_n_rd", n_rd, 1);
        check("done_start_mem", 32'(mem[10'h270]), 32'h1070);
        check("done_start_other", 32'(mem[10'h360]), 32'h1360);

        // full-RAM self copy
        for (int k = 0; k < 1024; k++) snap[k] = mem[k];
        run(10'h000, 10'h000, 11'd1024, 1100, 0, 0);
        check("full_done_cyc", done_cyc, 1026);
        check("full_error", err_at_done, 0);
        check("full_n_rd", n_rd, 1024);
        check("full_n_wr", n_wr, 1024);
        check("full_last_wr", last_wr, 1025);
        check("full_blk", blk_bad, 0);
        begin
            int diffs;
            diffs = 0;
            for (int k = 0; k < 1024; k++) if (mem[k] !== snap[k]) diffs++;
            check("full_ram_unchanged", diffs, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
